tt_um_emern_rasterizer: RTL
===========================

# tt_um_emern_rasterizer

Scanline rasterizer directly downstream of the SPI polygon frontend. It consumes the packed polygon, vertex, colour, enable and background registers and produces one 6-bit colour per logical pixel. Edge functions are evaluated incrementally: a serial setup pass runs per line during HBLANK, then there is one add per edge per pixel step. The output feeds the VGA colour DAC stage.

## Interface
- `N_EDGE`, 3: edges per polygon (fixed, not overridable).
- `WACC`, 17: signed edge-accumulator width.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `line_start` in 1: one-cycle pulse during HBLANK; begins setup for line `line_y`.
- `line_y` in `WPY`: logical y of the upcoming line, sampled with `line_start`.
- `px_step` in 1: one-cycle pulse per logical pixel; emits the pixel at current x, then advances x.
- `bg_color_in` in `WCOLOR`: background colour.
- `poly_color_in` in `WCOLOR*N_POLY`: packed colours, polygon 0 in the LSBs.
- `v0_x_in`, `v1_x_in`, `v2_x_in` in `WPX*N_POLY`: packed vertex x.
- `v0_y_in`, `v1_y_in`, `v2_y_in` in `WPY*N_POLY`: packed vertex y.
- `poly_enable_in` in `N_POLY`: per-polygon enable.
- `busy` out 1: high while setup runs; `px_step` is ignored while high.
- `pixel_color_out` out `WCOLOR`: registered colour of the last emitted pixel.
- `hit_out` out `N_POLY`: registered per-polygon coverage of the last emitted pixel.

## Operation
- **Snapshot.** On an accepted `line_start`, all polygon inputs, `bg_color_in` and `line_y` are latched into shadow registers. The frontend may rewrite its registers mid-line without tearing.
- **Edges.** For polygon p, edge 0 runs v0→v1, edge 1 runs v1→v2, edge 2 runs v2→v0.
- **Edge function.** E(x,y) = (x−xa)(yb−ya) − (y−ya)(xb−xa).
  - Operands are sign-extended: dx is 8-bit signed, dy is 7-bit signed, and each product is 15-bit.
  - The result is held in a `WACC` signed accumulator, which never overflows for the legal ranges.
- **FSM states: IDLE, SETUP, RUN.**
  - IDLE → SETUP on `line_start`.
  - SETUP computes E(0, line_y) for one edge per cycle, 12 cycles in total, ordered polygon-major then edge. It uses one shared multiplier pair. Each cycle also stores that edge's x-increment (yb−ya, 7-bit signed).
  - SETUP → RUN after the 12th edge. x resets to 0.
  - RUN: each `px_step` evaluates coverage at the current x, registers the outputs, adds the increment to all 12 accumulators, and increments x.
  - RUN → SETUP on `line_start`.
- **Coverage.** Polygon p covers a pixel iff its shadow enable is 1 and either all three E ≥ 0 or all three E ≤ 0. The test is inclusive and covers both windings.
  - A degenerate triangle (all vertices collinear) covers the pixels on its line.
- **Priority.** The highest-index covering polygon wins (D over C over B over A). If no polygon covers the pixel, the output is the shadow background colour.
- **x saturation.** x saturates at 127. A `px_step` at x=127 emits the pixel, after which further steps on that line are ignored and the outputs hold.
- **Reset values.**
  - FSM returns to IDLE; `busy`=0.
  - `pixel_color_out`=0 and `hit_out`=0.
  - Shadow registers and accumulators are set to 0.
- **In IDLE,** `px_step` is ignored and the outputs hold.

## Timing
- **Setup window.** With `line_start` sampled at cycle t:
  - Snapshot is taken at t.
  - `busy` is high for cycles t+1 through t+12.
  - The first accepted `px_step` is at t+13 or later.
- **Output latency.** `pixel_color_out` and `hit_out` update one cycle after `px_step` is sampled and hold until the next accepted step.
- **Back-to-back steps.** `px_step` may be high on consecutive cycles; one pixel is emitted per cycle at full rate.
- **`line_start` during SETUP.** Setup aborts and restarts at the new t, with a fresh snapshot.
- **`line_start` and `px_step` on the same cycle.** `line_start` wins and the step is dropped.
- **`rst` mid-SETUP or mid-RUN.** Everything returns to reset values on the next edge. No pixel is emitted until a new `line_start` plus 12 cycles.

## Structure
- **Shared constants.** `WCOLOR`, `WPX`, `WPY` and `N_POLY` stay in the shared `constants.v`. Add `WACC` and `N_EDGE` there.
- **Sub-module `tt_um_emern_edge_setup`.** Combinational: it takes (xa, ya, xb, yb, y) and returns the E(0,y) seed and the increment, and is instantiated once, time-shared across the 12 setup cycles.
- **Top level.** The top holds the FSM, shadow registers, 12 accumulators, x counter and priority mux.

## Test plan
- **Single triangle.** Poly A = v0(10,10), v1(20,10), v2(10,20), colour 0x30, enabled; bg 0x01; `line_start` with y=12; then 128 steps → pixels x=10..18 are 0x30 with `hit_out`=0001, and all others are 0x01.
- **Overlap priority.** Poly B identical to A with colour 0x0C; same line → x=10..18 give 0x0C with `hit_out`=0011.
- **Disabled and reversed winding.** Poly A is disabled → line y=12 is all 0x01. Poly A with v1 and v2 swapped is re-enabled → coverage matches the first scenario.
- **Setup timing.** `line_start` at t → `busy` is high for exactly t+1..t+12. A `px_step` at t+5 is ignored (x stays 0). The first pixel is emitted for a step at t+13.
- **Snapshot isolation.** Poly A colour is changed to 0x3F after `line_start`, during RUN → the rest of the line still shows 0x30. The next line shows 0x3F.
- **Boundaries.** 130 steps on one line → outputs hold after x=127. `rst` pulsed at x=15 → outputs are 0 and `busy`=0, and steps are ignored until a new `line_start`.

Source files
------------

// File: rtl/tt_um_emern_rasterizer_pkg.sv
// Shared widths and FSM encodings for the scanline rasterizer.
package tt_um_emern_rasterizer_pkg;
    localparam int WCOLOR = 6;
    localparam int WPX    = 7;
    localparam int WPY    = 6;
    localparam int N_POLY = 4;
    localparam int N_EDGE = 3;
    localparam int WACC   = 17;
    localparam int N_ACC  = N_POLY * N_EDGE;
    localparam int WINC   = WPY + 1;
    localparam int WPROD  = WPX + WPY + 2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
endpackage

// File: rtl/tt_um_emern_edge_setup.sv
// Combinational edge-function seed E(0,y) and per-pixel x increment for one edge a->b.
module tt_um_emern_edge_setup
    import tt_um_emern_rasterizer_pkg::*;
(
    input  logic [WPX-1:0]         xa,
    input  logic [WPY-1:0]         ya,
    input  logic [WPX-1:0]         xb,
    input  logic [WPY-1:0]         yb,
    input  logic [WPY-1:0]         y,
    output logic signed [WACC-1:0] seed,
    output logic signed [WINC-1:0] inc
);
    logic signed [WPX:0]     neg_xa, dx;
    logic signed [WPY:0]     dy, ey;
    logic signed [WPROD-1:0] p0, p1;

    assign neg_xa = -$signed({1'b0, xa});
    assign dx     = $signed({1'b0, xb}) - $signed({1'b0, xa});
    assign dy     = $signed({1'b0, yb}) - $signed({1'b0, ya});
    assign ey     = $signed({1'b0, y}) - $signed({1'b0, ya});

    assign p0   = WPROD'(neg_xa) * WPROD'(dy);
    assign p1   = WPROD'(ey) * WPROD'(dx);
    assign seed = WACC'(p0) - WACC'(p1);
    assign inc  = dy;
endmodule

// File: rtl/tt_um_emern_rasterizer.sv
// Scanline rasterizer: per-line serial edge setup, then one add per edge per pixel step.
module tt_um_emern_rasterizer
    import tt_um_emern_rasterizer_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     line_start,
    input  logic [WPY-1:0]           line_y,
    input  logic                     px_step,
    input  logic [WCOLOR-1:0]        bg_color_in,
    input  logic [WCOLOR*N_POLY-1:0] poly_color_in,
    input  logic [WPX*N_POLY-1:0]    v0_x_in,
    input  logic [WPX*N_POLY-1:0]    v1_x_in,
    input  logic [WPX*N_POLY-1:0]    v2_x_in,
    input  logic [WPY*N_POLY-1:0]    v0_y_in,
    input  logic [WPY*N_POLY-1:0]    v1_y_in,
    input  logic [WPY*N_POLY-1:0]    v2_y_in,
    input  logic [N_POLY-1:0]        poly_enable_in,
    output logic                     busy,
    output logic [WCOLOR-1:0]        pixel_color_out,
    output logic [N_POLY-1:0]        hit_out
);
    logic [1:0]                 state;
    logic [WCOLOR*N_POLY-1:0]   sh_color;
    logic [WPX*N_POLY-1:0]      sh_v0_x, sh_v1_x, sh_v2_x;
    logic [WPY*N_POLY-1:0]      sh_v0_y, sh_v1_y, sh_v2_y;
    logic [N_POLY-1:0]          sh_en;
    logic [WCOLOR-1:0]          sh_bg;
    logic [WPY-1:0]             sh_y;
    logic signed [WACC-1:0]     acc   [N_ACC];
    logic signed [WINC-1:0]     inc_r [N_ACC];
    logic [WPX-1:0]             x;
    logic                       x_done;
    logic [1:0]                 setup_poly, setup_edge;
    logic [3:0]                 setup_idx;

    logic [WPX-1:0]             vx0, vx1, vx2, xa, xb;
    logic [WPY-1:0]             vy0, vy1, vy2, ya, yb;
    logic signed [WACC-1:0]     seed;
    logic signed [WINC-1:0]     inc;
    logic [N_POLY-1:0]          cov;
    logic [WCOLOR-1:0]          color;
    logic                       all_ge, all_le, step_ok;

    assign busy      = (state == ST_SETUP);
    assign setup_idx = {2'b00, setup_poly} * 4'd3 + {2'b00, setup_edge};
    assign step_ok   = (state == ST_RUN) && px_step && !line_start && !x_done;

    // Edge e runs from vertex e to vertex (e+1) mod 3.
    always_comb begin
        vx0 = sh_v0_x[setup_poly*WPX +: WPX];
        vx1 = sh_v1_x[setup_poly*WPX +: WPX];
        vx2 = sh_v2_x[setup_poly*WPX +: WPX];
        vy0 = sh_v0_y[setup_poly*WPY +: WPY];
        vy1 = sh_v1_y[setup_poly*WPY +: WPY];
        vy2 = sh_v2_y[setup_poly*WPY +: WPY];
        case (setup_edge)
            2'd0:    begin xa = vx0; ya = vy0; xb = vx1; yb = vy1; end
            2'd1:    begin xa = vx1; ya = vy1; xb = vx2; yb = vy2; end
            default: begin xa = vx2; ya = vy2; xb = vx0; yb = vy0; end
        endcase
    end

    tt_um_emern_edge_setup u_edge_setup (
        .xa   (xa),
        .ya   (ya),
        .xb   (xb),
        .yb   (yb),
        .y    (sh_y),
        .seed (seed),
        .inc  (inc)
    );

    // Later polygons overwrite earlier ones, giving highest-index priority.
    always_comb begin
        cov    = '0;
        color  = sh_bg;
        all_ge = 1'b1;
        all_le = 1'b1;
        for (int p = 0; p < N_POLY; p++) begin
            all_ge = 1'b1;
            all_le = 1'b1;
            for (int e = 0; e < N_EDGE; e++) begin
                if (acc[p*N_EDGE+e] < 0) all_ge = 1'b0;
                if (acc[p*N_EDGE+e] > 0) all_le = 1'b0;
            end
            cov[p] = sh_en[p] & (all_ge | all_le);
            if (cov[p]) color = sh_color[p*WCOLOR +: WCOLOR];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            sh_color        <= '0;
            sh_v0_x         <= '0;
            sh_v1_x         <= '0;
            sh_v2_x         <= '0;
            sh_v0_y         <= '0;
            sh_v1_y         <= '0;
            sh_v2_y         <= '0;
            sh_en           <= '0;
            sh_bg           <= '0;
            sh_y            <= '0;
            x               <= '0;
            x_done          <= 1'b0;
            setup_poly      <= '0;
            setup_edge      <= '0;
            pixel_color_out <= '0;
            hit_out         <= '0;
            for (int k = 0; k < N_ACC; k++) begin
                acc[k]   <= '0;
                inc_r[k] <= '0;
            end
        end else if (line_start) begin
            state      <= ST_SETUP;
            sh_color   <= poly_color_in;
            sh_v0_x    <= v0_x_in;
            sh_v1_x    <= v1_x_in;
            sh_v2_x    <= v2_x_in;
            sh_v0_y    <= v0_y_in;
            sh_v1_y    <= v1_y_in;
            sh_v2_y    <= v2_y_in;
            sh_en      <= poly_enable_in;
            sh_bg      <= bg_color_in;
            sh_y       <= line_y;
            setup_poly <= '0;
            setup_edge <= '0;
        end else begin
            case (state)
                ST_SETUP: begin
                    acc[setup_idx]   <= seed;
                    inc_r[setup_idx] <= inc;
                    if (setup_edge == 2'd2) begin
                        setup_edge <= '0;
                        if (setup_poly == 2'(N_POLY - 1)) begin
                            state  <= ST_RUN;
                            x      <= '0;
                            x_done <= 1'b0;
                        end else begin
                            setup_poly <= setup_poly + 2'd1;
                        end
                    end else begin
                        setup_edge <= setup_edge + 2'd1;
                    end
                end
                ST_RUN: begin
                    if (step_ok) begin
                        pixel_color_out <= color;
                        hit_out         <= cov;
                        for (int k = 0; k < N_ACC; k++) begin
                            acc[k] <= acc[k] + WACC'(inc_r[k]);
                        end
                        if (x == {WPX{1'b1}}) x_done <= 1'b1;
                        else                  x      <= x + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
